mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory controller and arbiter between the instruction-fetch stage and the MEM stage. It owns the byte-wide external RAM port, serializes 32-bit fetches and 1/2/4-byte loads and stores into byte transfers, and returns results with one-cycle done pulses. Fetches can be cancelled by the pipeline's discard signal, the same signal that flushes the IF/ID register on a taken branch or mispredict.

## Interface
Parameters:
- none; address width is fixed at 32 bits and RAM data at 8 bits.

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- discard  in  1  cancel any pending or in-flight instruction fetch
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address, stable while if_req is high
- if_done  out  1  one-cycle pulse, if_inst valid this cycle
- if_inst  out  32  fetched word, little-endian
- mem_req  in  1  data request, held until mem_done
- mem_write  in  1  1 = store, 0 = load
- mem_len  in  2  0 = byte, 1 = half, 2 or 3 = word
- mem_addr  in  32  data byte address, stable while mem_req is high
- mem_wdata  in  32  store data; byte k is bits [8k+7:8k]
- mem_done  out  1  one-cycle pulse, load or store complete
- mem_rdata  out  32  load data, zero-extended, valid with mem_done
- busy  out  1  high in any non-IDLE state
- ram_addr  out  32  RAM byte address, registered
- ram_wr  out  1  RAM write enable, registered
- ram_dout  out  8  RAM write data, registered
- ram_din  in  8  RAM read data, valid one cycle after ram_addr is presented

## Operation
- States: IDLE, FETCH, LOAD, STORE, ACK.
- IDLE arbitration at each edge: mem_req has priority over if_req. The winner's address, length, and wdata are latched, the 3-bit byte counter cnt is cleared, and the state moves to LOAD, STORE, or FETCH.
- N = 4 for fetch. For data, N = 1, 2, or 4 from mem_len.
- LOAD/FETCH:
  - Drive ram_addr = base + cnt for cnt = 0..N-1 on consecutive cycles, with ram_wr = 0.
  - Capture the returning byte k into result bits [8k+7:8k] one cycle later.
  - After the last byte is captured, pulse the matching done output and enter ACK.
- STORE:
  - Drive ram_wr = 1, ram_addr = base + k, and ram_dout = wdata byte k for k = 0..N-1.
  - After the last byte, ram_wr returns to 0, mem_done pulses, and the state enters ACK.
- ACK: a one-cycle dead cycle. No arbitration occurs, which lets the requester deassert req. Next state is IDLE.
- Address arithmetic is 32-bit modulo 2^32. 0xFFFFFFFF + 1 wraps to 0. Unaligned accesses are legal.
- mem_rdata upper unused bytes are 0. Sign extension belongs to the MEM stage.
- discard:
  - Sampled high in FETCH or IDLE: the fetch is dropped and the state returns to IDLE at that edge, with no if_done.
  - If discard is high on the edge that would raise if_done, the pulse is suppressed.
  - Loads and stores are never aborted.
  - discard in IDLE also blocks fetch acceptance at that edge. A data request is still accepted.

## Timing
- Reset values: state IDLE, cnt 0, all outputs 0 (ram_addr, ram_wr, ram_dout, if_done, if_inst, mem_done, mem_rdata, busy).
- Reset mid-operation: IDLE at that edge and ram_wr = 0 at once. A partially written store stays partial; no done pulse.
- Acceptance edge is E0.
- Read of N bytes:
  - ram_addr = base during E0..E1.
  - The last byte is captured at E(N+1), the same edge that raises done.
  - A fetch therefore has if_done high during E5..E6.
- Store of N bytes: ram_wr high for exactly N cycles (E0..E(N)); mem_done rises at E(N).
- After the done cycle comes one ACK cycle, then IDLE. Earliest next acceptance is 2 edges after done rises.
- Back-to-back fetches therefore cost 7 cycles each.
- busy is high from E0 until the edge that enters IDLE.
- if_done and mem_done are never high in the same cycle.

## Test plan
- Fetch at 0x00000100 with RAM bytes 13 05 00 00 → if_done exactly one cycle, 5 cycles after acceptance, if_inst = 0x00000513; ram_wr stays 0.
- if_req and mem_req (load, len 1, addr 0x1002, RAM bytes AB CD) raised on the same edge → load served first, mem_rdata = 0x0000CDAB; fetch accepted 2 edges after mem_done.
- Store word 0xDEADBEEF at 0x2000 → ram_wr high 4 cycles with addresses 0x2000..0x2003 and data EF BE AD DE; mem_done 4 cycles after acceptance.
- discard pulsed 2 cycles into a fetch → no if_done, state IDLE next edge; a subsequent fetch returns correct data. discard on the if_done edge → pulse suppressed.
- Load byte at 0xFFFFFFFF, then half at 0xFFFFFFFF → second access issues addresses 0xFFFFFFFF then 0x00000000.
- reset asserted mid-store after 2 bytes → ram_wr 0 next cycle, all outputs 0, no mem_done; a new request is accepted normally after reset deasserts.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port byte-wide RAM controller arbitrating instruction fetch and MEM-stage data accesses.
// Ports: clock/reset; if_* fetch handshake; mem_* data handshake; busy; ram_* external byte RAM.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        discard,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_inst,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [1:0]  mem_len,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        busy,
    output logic [31:0] ram_addr,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din
);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, STORE, ACK} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] base;
    logic [31:0] wdata;
    logic [31:0] rbuf;

    logic [2:0]  nxt;
    logic [1:0]  ridx;
    logic [1:0]  widx;
    logic [2:0]  len_n;
    logic [31:0] merged;
    logic [7:0]  wsel;

    // cnt counts edges since acceptance; the byte arriving now was
    // addressed two edges ago, hence the capture index is cnt-1.
    always_comb begin
        nxt    = cnt + 3'd1;
        ridx   = cnt[1:0] - 2'd1;
        widx   = nxt[1:0];
        len_n  = (mem_len == 2'd0) ? 3'd1 :
                 (mem_len == 2'd1) ? 3'd2 : 3'd4;
        merged = rbuf;
        merged[8*ridx +: 8] = ram_din;
        wsel   = wdata[8*widx +: 8];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            n_bytes   <= 3'd0;
            base      <= 32'd0;
            wdata     <= 32'd0;
            rbuf      <= 32'd0;
            if_done   <= 1'b0;
            if_inst   <= 32'd0;
            mem_done  <= 1'b0;
            mem_rdata <= 32'd0;
            busy      <= 1'b0;
            ram_addr  <= 32'd0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_req) begin
                        base     <= mem_addr;
                        wdata    <= mem_wdata;
                        n_bytes  <= len_n;
                        cnt      <= 3'd0;
                        rbuf     <= 32'd0;
                        ram_addr <= mem_addr;
                        busy     <= 1'b1;
                        if (mem_write) begin
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                            state    <= STORE;
                        end else begin
                            state    <= LOAD;
                        end
                    end else if (if_req && !discard) begin
                        base     <= if_addr;
                        n_bytes  <= 3'd4;
                        cnt      <= 3'd0;
                        rbuf     <= 32'd0;
                        ram_addr <= if_addr;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH, LOAD: begin
                    // Only fetches are cancellable; this also
                    // swallows an if_done that would rise now.
                    if (state == FETCH && discard) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= nxt;
                        if (nxt < n_bytes)
                            ram_addr <= base + 32'(nxt);
                        if (cnt != 3'd0)
                            rbuf <= merged;
                        if (cnt == n_bytes) begin
                            state <= ACK;
                            if (state == FETCH) begin
                                if_done <= 1'b1;
                                if_inst <= merged;
                            end else begin
                                mem_done  <= 1'b1;
                                mem_rdata <= merged;
                            end
                        end
                    end
                end
                STORE: begin
                    cnt <= nxt;
                    if (nxt == n_bytes) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        state    <= ACK;
                    end else begin
                        ram_addr <= base + 32'(nxt);
                        ram_dout <= wsel;
                    end
                end
                ACK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a byte RAM model.
// Checks latency, ordering, store bytes, discard, wraparound and reset.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        discard;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_write;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        busy;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;

    mem_arbiter dut (
        .clock(clock), .reset(reset), .discard(discard),
        .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_inst(if_inst),
        .mem_req(mem_req), .mem_write(mem_write),
        .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_done(mem_done),
        .mem_rdata(mem_rdata), .busy(busy),
        .ram_addr(ram_addr), .ram_wr(ram_wr),
        .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clock = ~clock;

    // RAM model: one-cycle read latency, low 16 address bits.
    logic [7:0]  ram [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_a  = 16'd0;
    logic [7:0]  pl_d  = 8'd0;

    always @(posedge clock) begin
        if (pl_en)
            ram[pl_a] <= pl_d;
        else if (ram_wr)
            ram[ram_addr[15:0]] <= ram_dout;
        ram_din <= ram[ram_addr[15:0]];
    end

    // Event monitor sampled 1 time unit after each edge.
    int          cyc = 0;
    int          acc_q[$];
    int          ifd_n = 0;
    int          md_n = 0;
    int          ifd_cyc = 0;
    int          md_cyc = 0;
    int          both_n = 0;
    logic [31:0] wa_q[$];
    logic [7:0]  wd_q[$];
    logic [31:0] a_q[$];
    logic        busy_q = 1'b0;

    always @(posedge clock) begin
        #1;
        cyc++;
        if (busy && !busy_q) acc_q.push_back(cyc);
        busy_q = busy;
        if (if_done) begin ifd_n++; ifd_cyc = cyc; end
        if (mem_done) begin md_n++; md_cyc = cyc; end
        if (if_done && mem_done) both_n++;
        if (ram_wr) begin
            wa_q.push_back(ram_addr);
            wd_q.push_back(ram_dout);
        end
        if (busy) a_q.push_back(ram_addr);
    end

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        @(negedge clock);
        pl_en = 1'b0;
    endtask

    task automatic wait_done(input bit is_if, input string tag);
        int n = 0;
        while (!(is_if ? if_done : mem_done) && n < 30) begin
            @(negedge clock);
            n++;
        end
        if (n >= 30) chk({tag, "_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] len,
                        input string tag);
        mem_req = 1'b1; mem_write = 1'b0;
        mem_len = len;  mem_addr = a;
        wait_done(1'b0, tag);
        mem_req = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    int s_acc, s_if, s_md, s_wr, s_a;

    initial begin
        reset = 1'b1; discard = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        mem_req = 1'b0; mem_write = 1'b0; mem_len = 2'd0;
        mem_addr = 32'd0; mem_wdata = 32'd0;
        repeat (3) @(negedge clock);

        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ram_addr", ram_addr, 32'd0);
        chk("rst_ram_wr_dout", {23'd0, ram_wr, ram_dout}, 32'd0);
        chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);

        poke(16'h0100, 8'h13); poke(16'h0101, 8'h05);
        poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
        poke(16'h1002, 8'hAB); poke(16'h1003, 8'hCD);
        poke(16'hFFFF, 8'h5A); poke(16'h0000, 8'h77);
        for (int i = 0; i < 4; i++) poke(16'h3000 + 16'(i), 8'h00);
        reset = 1'b0;
        @(negedge clock);

        // Plain fetch
        s_acc = acc_q.size(); s_if = ifd_n; s_wr = wa_q.size();
        if_req = 1'b1; if_addr = 32'h100;
        wait_done(1'b1, "t1");
        if_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("t1_inst", if_inst, 32'h00000513);
        chk("t1_ndone", 32'(ifd_n - s_if), 32'd1);
        chk("t1_lat", 32'(ifd_cyc - acc_q[s_acc]), 32'd5);
        chk("t1_nowr", 32'(wa_q.size() - s_wr), 32'd0);

        // Simultaneous requests: load wins
        s_acc = acc_q.size();
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_write = 1'b0;
        mem_len = 2'd1; mem_addr = 32'h1002;
        wait_done(1'b0, "t2m");
        mem_req = 1'b0;
        chk("t2_rdata", mem_rdata, 32'h0000CDAB);
        wait_done(1'b1, "t2f");
        if_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("t2_mlat", 32'(md_cyc - acc_q[s_acc]), 32'd3);
        chk("t2_order", {31'd0, md_cyc < ifd_cyc}, 32'd1);
        chk("t2_gap", 32'(acc_q[s_acc+1] - md_cyc), 32'd2);
        chk("t2_inst", if_inst, 32'h00000513);

        // Word store
        s_acc = acc_q.size(); s_wr = wa_q.size();
        mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
        wait_done(1'b0, "t3");
        mem_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("t3_nwr", 32'(wa_q.size() - s_wr), 32'd4);
        chk("t3_lat", 32'(md_cyc - acc_q[s_acc]), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_addr%0d", i), wa_q[s_wr+i],
                32'h2000 + 32'(i));
            chk($sformatf("t3_data%0d", i), {24'd0, wd_q[s_wr+i]},
                {24'd0, mem_wdata[8*i +: 8]});
        end

        // Discard two cycles into a fetch
        s_if = ifd_n;
        if_req = 1'b1; if_addr = 32'h100;
        repeat (2) @(negedge clock);
        discard = 1'b1; if_req = 1'b0;
        @(negedge clock);
        discard = 1'b0;
        chk("t4a_idle", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clock);
        chk("t4a_nodone", 32'(ifd_n - s_if), 32'd0);

        // Discard on the done edge
        if_req = 1'b1; if_addr = 32'h100;
        repeat (5) @(negedge clock);
        discard = 1'b1; if_req = 1'b0;
        @(negedge clock);
        discard = 1'b0;
        chk("t4b_idle", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clock);
        chk("t4b_nodone", 32'(ifd_n - s_if), 32'd0);

        if_req = 1'b1; if_addr = 32'h100;
        wait_done(1'b1, "t4c");
        if_req = 1'b0;
        repeat (3) @(negedge clock);
        chk("t4c_inst", if_inst, 32'h00000513);
        chk("t4c_ndone", 32'(ifd_n - s_if), 32'd1);

        // Address wrap
        load(32'hFFFFFFFF, 2'd0, "t5a");
        chk("t5a_rdata", mem_rdata, 32'h0000005A);
        s_a = a_q.size();
        load(32'hFFFFFFFF, 2'd1, "t5b");
        chk("t5b_addr0", a_q[s_a], 32'hFFFFFFFF);
        chk("t5b_addr1", a_q[s_a+1], 32'h00000000);
        chk("t5b_rdata", mem_rdata, 32'h0000775A);

        // Reset mid-store after two bytes
        s_md = md_n;
        mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd2;
        mem_addr = 32'h3000; mem_wdata = 32'h11223344;
        repeat (2) @(negedge clock);
        reset = 1'b1; mem_req = 1'b0;
        @(negedge clock);
        chk("t6_wr", {31'd0, ram_wr}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_addr", ram_addr, 32'd0);
        chk("t6_rdata", mem_rdata, 32'd0);
        chk("t6_dout", {24'd0, ram_dout}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        chk("t6_nodone", 32'(md_n - s_md), 32'd0);
        load(32'h3000, 2'd3, "t6a");
        chk("t6_partial", mem_rdata, 32'h00003344);
        load(32'h2000, 2'd2, "t6b");
        chk("t6_word", mem_rdata, 32'hDEADBEEF);

        chk("both_done", 32'(both_n), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
